// File: rtl/spi_slave_burst_pkg.sv
// Shared state encoding and opcodes for the spi_slave_burst front-end.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_CMD   = 3'd1,
        ST_RX_DATA  = 3'd2,
        ST_TX_WAIT  = 3'd3,
        ST_TX_SHIFT = 3'd4,
        ST_DRAIN    = 3'd5
    } spi_state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_burst_shifter.sv
// Shared receive/transmit shift register with a bit counter whose modulus is
// DATA_W+2 for command words and DATA_W for payload words.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic              cmd_mod,
    input  logic              shift_in,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W:0]   shreg,
    output logic [CNT_W-1:0]  cnt,
    output logic              last_bit
);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W:0]  shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_bit_s;

    // Last position of the current word, depending on the active modulus.
    always_comb begin
        if (cmd_mod) begin
            last_bit_s = (cnt_r == CMD_LAST);
        end else begin
            last_bit_s = (cnt_r == DATA_LAST);
        end
    end

    // Shift/load/clear of the data register and wrap of the bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {(DATA_W+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (clr) begin
            shreg_r <= {(DATA_W+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load) begin
            shreg_r <= {1'b0, load_data};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (shift) begin
            shreg_r <= {shreg_r[DATA_W-1:0], shift_in};
            cnt_r   <= last_bit_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

    assign shreg    = shreg_r;
    assign cnt      = cnt_r;
    assign last_bit = last_bit_s;

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end with opcode framing, handshaked read path and abort detection.
// Define SPI_SLAVE_BURST_EN to enable burst write streaming and burst read re-requests.
module spi_slave_burst
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    spi_state_t        state_r, next_state_s;
    logic              sh_clr_s, sh_load_s, sh_shift_s, sh_cmd_mod_s;
    logic [DATA_W:0]   shreg_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              last_bit_s;
    logic              rx_fire_s, miso_nxt_s, frame_err_s;
    logic [DATA_W+1:0] rx_word_s;
    logic              busy_r, rx_valid_r, miso_r, frame_err_r;
    logic [DATA_W+1:0] rx_data_r;

    spi_shifter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr       (sh_clr_s),
        .load      (sh_load_s),
        .shift     (sh_shift_s),
        .cmd_mod   (sh_cmd_mod_s),
        .shift_in  (mosi),
        .load_data (tx_data),
        .shreg     (shreg_s),
        .cnt       (cnt_s),
        .last_bit  (last_bit_s)
    );

    // Next-state, shifter control and next output values.
    always_comb begin
        next_state_s = state_r;
        sh_clr_s     = 1'b0;
        sh_load_s    = 1'b0;
        sh_shift_s   = 1'b0;
        sh_cmd_mod_s = 1'b0;
        rx_fire_s    = 1'b0;
        rx_word_s    = {(DATA_W+2){1'b0}};
        miso_nxt_s   = 1'b0;
        frame_err_s  = 1'b0;
        if (ss_n) begin
            // Frame end: a partial word or an interrupted transmit is an abort.
            next_state_s = ST_IDLE;
            sh_clr_s     = 1'b1;
            if ((state_r == ST_TX_SHIFT) ||
                (((state_r == ST_RX_CMD) || (state_r == ST_RX_DATA)) && (cnt_s != {CNT_W{1'b0}}))) begin
                frame_err_s = 1'b1;
            end else begin
                frame_err_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sh_shift_s   = 1'b1;
                    sh_cmd_mod_s = 1'b1;
                    next_state_s = ST_RX_CMD;
                end
                ST_RX_CMD: begin
                    sh_shift_s   = 1'b1;
                    sh_cmd_mod_s = 1'b1;
                    if (last_bit_s) begin
                        rx_fire_s = 1'b1;
                        rx_word_s = {shreg_s, mosi};
                        case (shreg_s[DATA_W:DATA_W-1])
                            OP_WR_DATA: begin
`ifdef SPI_SLAVE_BURST_EN
                                next_state_s = ST_RX_DATA;
`else
                                next_state_s = ST_DRAIN;
`endif
                            end
                            OP_RD_DATA:             next_state_s = ST_TX_WAIT;
                            OP_WR_ADDR, OP_RD_ADDR: next_state_s = ST_DRAIN;
                            default:                next_state_s = ST_DRAIN;
                        endcase
                    end else begin
                        next_state_s = ST_RX_CMD;
                    end
                end
`ifdef SPI_SLAVE_BURST_EN
                ST_RX_DATA: begin
                    sh_shift_s = 1'b1;
                    if (last_bit_s) begin
                        rx_fire_s = 1'b1;
                        rx_word_s = {OP_WR_DATA, shreg_s[DATA_W-2:0], mosi};
                    end else begin
                        rx_fire_s = 1'b0;
                    end
                end
`endif
                ST_TX_WAIT: begin
                    if (tx_valid) begin
                        sh_load_s    = 1'b1;
                        miso_nxt_s   = tx_data[DATA_W-1];
                        next_state_s = ST_TX_SHIFT;
                    end else begin
                        next_state_s = ST_TX_WAIT;
                    end
                end
                ST_TX_SHIFT: begin
                    // MSB was presented at load; bit DATA_W-2 is always the next one out.
                    sh_shift_s = 1'b1;
                    if (last_bit_s) begin
                        miso_nxt_s = 1'b0;
`ifdef SPI_SLAVE_BURST_EN
                        rx_fire_s    = 1'b1;
                        rx_word_s    = {OP_RD_DATA, {DATA_W{1'b0}}};
                        next_state_s = ST_TX_WAIT;
`else
                        next_state_s = ST_DRAIN;
`endif
                    end else begin
                        miso_nxt_s = shreg_s[DATA_W-2];
                    end
                end
                ST_DRAIN: begin
                    next_state_s = ST_DRAIN;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    sh_clr_s     = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= {(DATA_W+2){1'b0}};
            miso_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != ST_IDLE);
            rx_valid_r  <= rx_fire_s;
            rx_data_r   <= rx_fire_s ? rx_word_s : rx_data_r;
            miso_r      <= miso_nxt_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign miso      = miso_r;
    assign rx_valid  = rx_valid_r;
    assign rx_data   = rx_data_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule
